wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port (write enable, destination index, write data) between two writeback requesters: the ALU path and the memory/long-latency path.
- Each requester uses a valid/ready handshake.
- Grants at most one write per cycle and drives the register-file write inputs from registered outputs.
- Drops writes to x0 without consuming the port and prevents ALU starvation with a bounded-wait counter.

Parameters:
- DATA_WIDTH, 32, width of write data.
- REG_DATA_WIDTH, 5, width of register index.
- STARVE_LIMIT, 4, number of consecutive blocked ALU cycles after which the ALU gets priority (1..15).
- CNT_WIDTH, 16, width of the conflict statistics counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU write request.
- alu_rd  input  REG_DATA_WIDTH  ALU destination register.
- alu_data  input  DATA_WIDTH  ALU write data.
- alu_ready  output  1  ALU request accepted this cycle (combinational).
- mem_valid  input  1  memory-path write request.
- mem_rd  input  REG_DATA_WIDTH  memory-path destination register.
- mem_data  input  DATA_WIDTH  memory-path write data.
- mem_ready  output  1  memory request accepted this cycle (combinational).
- RegWrite  output  1  register-file write enable (registered).
- rd  output  REG_DATA_WIDTH  register-file write index (registered).
- ALUout  output  DATA_WIDTH  register-file write data (registered).
- conflict_cnt  output  CNT_WIDTH  count of cycles in which both requesters wanted the port.

Behaviour:
- Reset (rst=1 at edge):
  - RegWrite=0, rd=0, ALUout=0, starve_cnt=0, conflict_cnt=0.
  - While rst=1, alu_ready=mem_ready=0 and no request is accepted.
- Transfer: a request is accepted when valid && ready in the same cycle. Requesters hold rd/data stable while valid && !ready.
- "Real" request: valid && rd!=0.
  - An x0 request (valid && rd==0) gets ready=1 immediately.
  - An x0 request never occupies the port and never asserts RegWrite.
- Arbitration among real requests (combinational, same cycle):
  - Only one real: it is granted.
  - Both real, starve_cnt < STARVE_LIMIT: mem granted (older instruction), alu_ready=0.
  - Both real, starve_cnt == STARVE_LIMIT: alu granted, mem_ready=0.
  - No real request: no grant.
- Output stage, 1-cycle latency: on the edge after a real grant, RegWrite=1, rd=granted rd, ALUout=granted data.
  - Otherwise RegWrite=0.
  - rd and ALUout hold their previous values when RegWrite=0.
- starve_cnt update:
  - +1 (saturating at STARVE_LIMIT) when ALU has a real request and alu_ready=0.
  - Cleared when an ALU real request transfers or alu_valid=0.
  - Unchanged when an ALU x0 request is accepted.
- conflict_cnt update:
  - +1 each cycle both requesters have real requests (not in reset).
  - Wraps modulo 2^CNT_WIDTH.
- Same destination from both requesters: no merging. Writes occur in grant order on consecutive cycles, so the last granted value ends up in the register.
- Mixed x0 cases in one cycle:
  - mem x0 + alu real: both accepted, ALU write issued.
  - Both x0: both accepted, RegWrite=0 next cycle.
- Reset mid-operation: a pending grant computed in the rst cycle is discarded. RegWrite=0 on the following cycle. No held requests are retained internally; requesters re-present after reset.
- No internal buffering: the arbiter adds exactly one register stage. Throughput is one real write per cycle.

Test Plan:
- Reset: assert rst 2 cycles with both valid, alu_rd=5, mem_rd=6 -> alu_ready=mem_ready=0, RegWrite=0, rd=0, ALUout=0, conflict_cnt=0.
- Single ALU write: alu_valid=1, alu_rd=3, alu_data=0xDEADBEEF for 1 cycle -> alu_ready=1 same cycle; next cycle RegWrite=1, rd=3, ALUout=0xDEADBEEF; following cycle RegWrite=0.
- Conflict priority: both valid every cycle, mem_rd=7/mem_data=0x11, alu_rd=8/alu_data=0x22, STARVE_LIMIT=4:
  - Cycles 0-3 grant mem, alu_ready=0.
  - Cycle 4 grants alu (mem_ready=0); starve_cnt clears.
  - conflict_cnt=5 after 5 cycles.
  - RegWrite trace: rd=7 x4, then rd=8.
- x0 filtering: mem_valid=1, mem_rd=0 and alu_valid=1, alu_rd=9, alu_data=0x5 -> both ready=1; next cycle RegWrite=1, rd=9, ALUout=0x5.
  - Both requesters to x0 -> both ready, RegWrite=0, conflict_cnt unchanged.
- Same-rd ordering: both real to rd=12, mem_data=0xA, alu_data=0xB, starve_cnt=0 -> writes 0xA then 0xB on consecutive cycles; final RegWrite rd=12, ALUout=0xB.
- Reset mid-stream: mem granted in cycle N with rst=1 in cycle N -> RegWrite=0 at N+1, starve_cnt=0, conflict_cnt=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single register-file write port between
// the ALU path and the memory/long-latency path. Memory wins conflicts (older
// instruction) until the ALU has been blocked STARVE_LIMIT consecutive cycles,
// then the ALU wins once. Writes to x0 are accepted but never use the port.
module wb_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_DATA_WIDTH = 5,
  parameter int STARVE_LIMIT   = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  input  logic [REG_DATA_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  output logic                      alu_ready,
  input  logic                      mem_valid,
  input  logic [REG_DATA_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  output logic                      mem_ready,
  output logic                      RegWrite,
  output logic [REG_DATA_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]     ALUout,
  output logic [CNT_WIDTH-1:0]      conflict_cnt
);

  // Starvation timer counts down from STARVE_LIMIT; zero means the ALU has
  // been blocked long enough and takes priority on the next conflict.
  localparam logic [3:0] STARVE_TC = 4'(STARVE_LIMIT);

  logic [3:0] starve_left;
  logic       alu_real;
  logic       mem_real;
  logic       alu_pri;
  logic       alu_grant;
  logic       mem_grant;

  // Same-cycle arbitration between real requests; x0 requests are acked freely.
  always_comb begin
    alu_real  = alu_valid && (alu_rd != '0);
    mem_real  = mem_valid && (mem_rd != '0);
    alu_pri   = (starve_left == 4'd0);
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (!rst) begin
      alu_grant = alu_real && (!mem_real || alu_pri);
      mem_grant = mem_real && (!alu_real || !alu_pri);
    end
    alu_ready = !rst && ((alu_valid && (alu_rd == '0)) || alu_grant);
    mem_ready = !rst && ((mem_valid && (mem_rd == '0)) || mem_grant);
  end

  // Output register stage, starvation timer and conflict statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite     <= 1'b0;
      rd           <= '0;
      ALUout       <= '0;
      starve_left  <= STARVE_TC;
      conflict_cnt <= '0;
    end else begin
      RegWrite <= alu_grant || mem_grant;
      if (alu_grant) begin
        rd     <= alu_rd;
        ALUout <= alu_data;
      end else if (mem_grant) begin
        rd     <= mem_rd;
        ALUout <= mem_data;
      end

      // An accepted x0 ALU request leaves the timer untouched.
      if (!alu_valid || alu_grant) begin
        starve_left <= STARVE_TC;
      end else if (alu_real && (starve_left != 4'd0)) begin
        starve_left <= starve_left - 4'd1;
      end

      if (alu_real && mem_real) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table followed by randomized
// traffic checked against a cycle-level reference model.
module tb_wb_port_arbiter;

  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int LIMIT = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid;
  logic [RW-1:0] alu_rd, mem_rd;
  logic [DW-1:0] alu_data, mem_data;
  logic          alu_ready, mem_ready;
  logic          RegWrite;
  logic [RW-1:0] rd;
  logic [DW-1:0] ALUout;
  logic [CW-1:0] conflict_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  wb_port_arbiter #(
    .DATA_WIDTH(DW), .REG_DATA_WIDTH(RW), .STARVE_LIMIT(LIMIT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .RegWrite(RegWrite), .rd(rd), .ALUout(ALUout), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          av;
    logic [RW-1:0] ard;
    logic [DW-1:0] adat;
    logic          mv;
    logic [RW-1:0] mrd;
    logic [DW-1:0] mdat;
    logic          e_ar;
    logic          e_mr;
    logic          e_we;
    logic [RW-1:0] e_rd;
    logic [DW-1:0] e_dat;
    logic [CW-1:0] e_cc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [RW-1:0] ard, input logic [DW-1:0] adat,
                       input logic mv, input logic [RW-1:0] mrd, input logic [DW-1:0] mdat);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = adat;
    mem_valid = mv; mem_rd = mrd; mem_data = mdat;
  endtask

  function automatic vec_t mk(input logic r, input logic av, input logic [RW-1:0] ard, input logic [DW-1:0] adat,
                              input logic mv, input logic [RW-1:0] mrd, input logic [DW-1:0] mdat,
                              input logic ear, input logic emr, input logic ewe,
                              input logic [RW-1:0] erd, input logic [DW-1:0] edat, input logic [CW-1:0] ecc);
    vec_t v;
    v.rst = r; v.av = av; v.ard = ard; v.adat = adat; v.mv = mv; v.mrd = mrd; v.mdat = mdat;
    v.e_ar = ear; v.e_mr = emr; v.e_we = ewe; v.e_rd = erd; v.e_dat = edat; v.e_cc = ecc;
    return v;
  endfunction

  // Reference model state: consecutive blocked ALU cycles and last write.
  int            m_starve;
  logic          m_we;
  logic [RW-1:0] m_rd;
  logic [DW-1:0] m_dat;
  logic [CW-1:0] m_cc;

  initial begin
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    @(posedge clk); #1;

    // ---------------- directed table ----------------
    // reset with both requesting
    vecs.push_back(mk(1, 1, 5, 32'h55, 1, 6, 32'h66, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 5, 32'h55, 1, 6, 32'h66, 0, 0, 0, 0, 0, 0));
    // single ALU write, then idle
    vecs.push_back(mk(0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 1, 0, 1, 3, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 32'hDEADBEEF, 0));
    // conflict: mem x4, then ALU after starvation
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk(0, 1, 8, 32'h22, 1, 7, 32'h11, 0, 1, 1, 7, 32'h11, CW'(i)));
    vecs.push_back(mk(0, 1, 8, 32'h22, 1, 7, 32'h11, 1, 0, 1, 8, 32'h22, 5));
    // pending mem drains alone
    vecs.push_back(mk(0, 0, 0, 0, 1, 7, 32'h11, 0, 1, 1, 7, 32'h11, 5));
    // mem x0 + alu real
    vecs.push_back(mk(0, 1, 9, 32'h5, 1, 0, 32'h77, 1, 1, 1, 9, 32'h5, 5));
    // both x0
    vecs.push_back(mk(0, 1, 0, 32'h99, 1, 0, 32'h88, 1, 1, 0, 9, 32'h5, 5));
    // same rd: mem first, then alu
    vecs.push_back(mk(0, 1, 12, 32'hB, 1, 12, 32'hA, 0, 1, 1, 12, 32'hA, 6));
    vecs.push_back(mk(0, 1, 12, 32'hB, 0, 0, 0, 1, 0, 1, 12, 32'hB, 6));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 32'hB, 6));
    // reset mid-stream: starvation progress and counter must be lost
    vecs.push_back(mk(0, 1, 8, 32'h22, 1, 7, 32'h11, 0, 1, 1, 7, 32'h11, 7));
    vecs.push_back(mk(1, 1, 8, 32'h22, 1, 7, 32'h11, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk(0, 1, 8, 32'h22, 1, 7, 32'h11, 0, 1, 1, 7, 32'h11, CW'(i)));
    vecs.push_back(mk(0, 1, 8, 32'h22, 1, 7, 32'h11, 1, 0, 1, 8, 32'h22, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 32'h22, 5));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].mv, vecs[i].mrd, vecs[i].mdat);
      #3;
      chk($sformatf("vec%0d alu_ready", i), DW'(alu_ready), DW'(vecs[i].e_ar));
      chk($sformatf("vec%0d mem_ready", i), DW'(mem_ready), DW'(vecs[i].e_mr));
      @(posedge clk); #1;
      chk($sformatf("vec%0d RegWrite", i), DW'(RegWrite), DW'(vecs[i].e_we));
      chk($sformatf("vec%0d rd", i), DW'(rd), DW'(vecs[i].e_rd));
      chk($sformatf("vec%0d ALUout", i), ALUout, vecs[i].e_dat);
      chk($sformatf("vec%0d conflict_cnt", i), DW'(conflict_cnt), DW'(vecs[i].e_cc));
    end

    // ---------------- randomized traffic vs model ----------------
    begin
      logic          r, av, mv, a_real, m_real, a_win, m_win, e_ar, e_mr;
      logic [RW-1:0] ard, mrd;
      logic [DW-1:0] adat, mdat;
      logic          a_hold, m_hold;
      a_hold = 0; m_hold = 0;
      av = 0; mv = 0; ard = '0; mrd = '0; adat = '0; mdat = '0;
      m_starve = 0; m_we = 0; m_rd = '0; m_dat = '0; m_cc = '0;

      for (int cyc = 0; cyc < 600; cyc++) begin
        r = (cyc < 2) || ($urandom_range(0, 29) == 0);
        if (!a_hold) begin
          av   = ($urandom_range(0, 3) != 0);
          ard  = ($urandom_range(0, 4) == 0) ? RW'(0) : RW'($urandom_range(1, 31));
          adat = $urandom;
        end
        if (!m_hold) begin
          mv   = ($urandom_range(0, 2) != 0);
          mrd  = ($urandom_range(0, 4) == 0) ? RW'(0) : RW'($urandom_range(1, 31));
          mdat = $urandom;
        end
        drive(r, av, ard, adat, mv, mrd, mdat);

        a_real = av && (ard != 0);
        m_real = mv && (mrd != 0);
        a_win  = !r && a_real && (!m_real || m_starve >= LIMIT);
        m_win  = !r && m_real && !a_win;
        e_ar   = !r && av && (ard == 0 || a_win);
        e_mr   = !r && mv && (mrd == 0 || m_win);

        #3;
        chk($sformatf("rnd%0d alu_ready", cyc), DW'(alu_ready), DW'(e_ar));
        chk($sformatf("rnd%0d mem_ready", cyc), DW'(mem_ready), DW'(e_mr));

        if (r) begin
          m_we = 0; m_rd = '0; m_dat = '0; m_cc = '0; m_starve = 0;
        end else begin
          m_we = a_win || m_win;
          if (a_win) begin m_rd = ard; m_dat = adat; end
          else if (m_win) begin m_rd = mrd; m_dat = mdat; end
          if (!av || a_win) m_starve = 0;
          else if (a_real && m_starve < LIMIT) m_starve++;
          if (a_real && m_real) m_cc = m_cc + 1'b1;
        end

        @(posedge clk); #1;
        chk($sformatf("rnd%0d RegWrite", cyc), DW'(RegWrite), DW'(m_we));
        chk($sformatf("rnd%0d rd", cyc), DW'(rd), DW'(m_rd));
        chk($sformatf("rnd%0d ALUout", cyc), ALUout, m_dat);
        chk($sformatf("rnd%0d conflict_cnt", cyc), DW'(conflict_cnt), DW'(m_cc));

        a_hold = av && !e_ar && !r;
        m_hold = mv && !e_mr && !r;
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
